// File: rtl/pkt_head_upd_merger.sv
// Packet head-update merger.
// Software head-pointer updates are parked in a small age-ordered table and are
// folded into the outgoing packet stream: a packet to a pending queue carries the
// update (needs_dsc=1); otherwise pending updates leave as descriptor-only beats,
// either when the packet stream is idle or after MAX_PKT_BURST packets have
// bypassed a non-empty table.
//
// Handshake: every stream transfers on a cycle where valid and ready are both
// high. out_meta_valid/out_meta_data are registered and held until accepted;
// in_meta_ready and head_upd_ready are combinational from pre-cycle state.

package pkt_head_upd_merger_pkg;
    localparam int QID_W = 8;
    typedef logic [QID_W-1:0] pkt_queue_id_t;

    typedef struct packed {
        pkt_queue_id_t pkt_queue_id;
        logic [15:0]   size;
        logic [15:0]   flow_tag;
        logic          needs_dsc;
        logic          descriptor_only;
    } pkt_meta_with_queues_t;
endpackage

module pkt_head_upd_merger
    import pkt_head_upd_merger_pkg::*;
#(
    parameter int NB_PENDING    = 4,
    parameter int MAX_PKT_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  pkt_meta_with_queues_t in_meta_data,
    input  logic                  in_meta_valid,
    output logic                  in_meta_ready,
    input  pkt_queue_id_t         head_upd_queue_id,
    input  logic                  head_upd_valid,
    output logic                  head_upd_ready,
    output pkt_meta_with_queues_t out_meta_data,
    output logic                  out_meta_valid,
    input  logic                  out_meta_ready,
    output logic [31:0]           merge_cnt,
    output logic [31:0]           coalesce_cnt
);

    localparam int IDX_W   = (NB_PENDING > 1) ? $clog2(NB_PENDING) : 1;
    localparam int BURST_W = (MAX_PKT_BURST > 0) ? $clog2(MAX_PKT_BURST + 1) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_PKT_BURST);

    // Pending table: entries 0..n-1 valid, entry 0 is the oldest.
    logic [NB_PENDING-1:0] tbl_vld_q, tbl_vld_d;
    pkt_queue_id_t         tbl_id_q [NB_PENDING];
    pkt_queue_id_t         tbl_id_d [NB_PENDING];

    logic [BURST_W-1:0]    burst_q, burst_d;
    pkt_meta_with_queues_t out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           merge_cnt_q, merge_cnt_d;
    logic [31:0]           coalesce_cnt_q, coalesce_cnt_d;

    logic                  tbl_full, tbl_empty;
    logic                  hu_hit, pkt_hit;
    logic [IDX_W-1:0]      hu_idx, pkt_idx, rem_idx;
    logic                  sel_en, rule1, rule2, rule3, rem;
    logic                  hu_fire, hu_coal, hu_ins, ins_done;

    // Table lookups for the incoming packet and head update (oldest match wins).
    always_comb begin
        hu_hit  = 1'b0;
        hu_idx  = '0;
        pkt_hit = 1'b0;
        pkt_idx = '0;
        for (int i = NB_PENDING - 1; i >= 0; i--) begin
            if (tbl_vld_q[i]) begin
                if (tbl_id_q[i] == head_upd_queue_id) begin
                    hu_hit = 1'b1;
                    hu_idx = IDX_W'(i);
                end
                if (tbl_id_q[i] == in_meta_data.pkt_queue_id) begin
                    pkt_hit = 1'b1;
                    pkt_idx = IDX_W'(i);
                end
            end
        end
    end

    assign tbl_full  = &tbl_vld_q;
    assign tbl_empty = ~|tbl_vld_q;

    // Output selection priority and handshake readies.
    always_comb begin
        sel_en         = !rst && (!out_valid_q || out_meta_ready);
        rule1          = sel_en && in_meta_valid && pkt_hit;
        rule2          = sel_en && !rule1 && !tbl_empty &&
                         ((burst_q >= BURST_MAX) || !in_meta_valid);
        rule3          = sel_en && !rule1 && !rule2 && in_meta_valid;
        rem            = rule1 || rule2;
        rem_idx        = rule1 ? pkt_idx : '0;
        in_meta_ready  = rule1 || rule3;
        // Full-table check ignores a same-cycle removal on purpose.
        head_upd_ready = !rst && (!tbl_full || hu_hit);
        hu_fire        = head_upd_valid && head_upd_ready;
        // An update matching the entry leaving this cycle must be re-inserted.
        hu_coal        = hu_fire && hu_hit && !(rem && (rem_idx == hu_idx));
        hu_ins         = hu_fire && !hu_coal;
    end

    // Next table contents: compact out the removed entry, then append new update.
    always_comb begin
        tbl_vld_d = tbl_vld_q;
        tbl_id_d  = tbl_id_q;
        ins_done  = 1'b0;
        if (rem) begin
            for (int i = 0; i < NB_PENDING - 1; i++) begin
                if (IDX_W'(i) >= rem_idx) begin
                    tbl_vld_d[i] = tbl_vld_q[i+1];
                    tbl_id_d[i]  = tbl_id_q[i+1];
                end
            end
            tbl_vld_d[NB_PENDING-1] = 1'b0;
            tbl_id_d[NB_PENDING-1]  = '0;
        end
        if (hu_ins) begin
            for (int i = 0; i < NB_PENDING; i++) begin
                if (!ins_done && !tbl_vld_d[i]) begin
                    tbl_vld_d[i] = 1'b1;
                    tbl_id_d[i]  = head_upd_queue_id;
                    ins_done     = 1'b1;
                end
            end
        end
    end

    // Next output beat, burst counter and event counters.
    always_comb begin
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        burst_d        = burst_q;
        merge_cnt_d    = merge_cnt_q + 32'(rule1);
        coalesce_cnt_d = coalesce_cnt_q + 32'(hu_coal);
        if (sel_en) begin
            out_valid_d = rule1 || rule2 || rule3;
            if (rule1) begin
                out_data_d           = in_meta_data;
                out_data_d.needs_dsc = 1'b1;
                burst_d              = '0;
            end else if (rule2) begin
                out_data_d                 = '0;
                out_data_d.pkt_queue_id    = tbl_id_q[0];
                out_data_d.descriptor_only = 1'b1;
                burst_d                    = '0;
            end else if (rule3) begin
                out_data_d           = in_meta_data;
                out_data_d.needs_dsc = 1'b0;
                if (tbl_empty) begin
                    burst_d = '0;
                end else if (burst_q < BURST_MAX) begin
                    burst_d = burst_q + BURST_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_vld_q      <= '0;
            for (int i = 0; i < NB_PENDING; i++) begin
                tbl_id_q[i] <= '0;
            end
            burst_q        <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            merge_cnt_q    <= '0;
            coalesce_cnt_q <= '0;
        end else begin
            tbl_vld_q      <= tbl_vld_d;
            tbl_id_q       <= tbl_id_d;
            burst_q        <= burst_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            merge_cnt_q    <= merge_cnt_d;
            coalesce_cnt_q <= coalesce_cnt_d;
        end
    end

    assign out_meta_data  = out_data_q;
    assign out_meta_valid = out_valid_q;
    assign merge_cnt      = merge_cnt_q;
    assign coalesce_cnt   = coalesce_cnt_q;

endmodule

// File: doc/pkt_head_upd_merger.md
PKT_HEAD_UPD_MERGER -- requirements
Module: pkt_head_upd_merger

Interface
REQ-001 SHALL have parameter NB_PENDING, default 4: number of pending head-update entries, range 2..16.
REQ-002 SHALL have parameter MAX_PKT_BURST, default 8: maximum consecutive packet outputs while a head update is pending.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports in_meta_data (input, pkt_meta_with_queues_t), in_meta_valid (input, 1 bit) and in_meta_ready (output, 1 bit): the packet metadata stream.
REQ-006 SHALL have ports head_upd_queue_id (input, width of pkt_queue_id), head_upd_valid (input, 1 bit) and head_upd_ready (output, 1 bit): software head-pointer update events.
REQ-007 SHALL have ports out_meta_data (output, pkt_meta_with_queues_t), out_meta_valid (output, 1 bit) and out_meta_ready (input, 1 bit): the stream to the packet queue manager.
REQ-008 SHALL have ports merge_cnt and coalesce_cnt, both output, 32 bits: event counters.

Function
REQ-009 SHALL transfer on any stream only on a cycle where valid and ready are both high; out_meta_valid/data SHALL be held stable until accepted.
REQ-010 SHALL keep a pending table of NB_PENDING entries, each a valid bit plus queue id, ordered by insertion age.
REQ-011 SHALL drive head_upd_ready = table not full OR head_upd_queue_id equals a valid entry, evaluated on pre-cycle state.
REQ-012 SHALL, for an accepted head update matching a valid entry not being removed this cycle, drop it and increment coalesce_cnt; otherwise it SHALL append it as the youngest entry.
REQ-013 SHALL register the output: out_meta_data and out_meta_valid SHALL update one cycle after selection, and selection SHALL happen only when !out_meta_valid || out_meta_ready.
REQ-014 SHALL, when selecting, apply priority rule 1: if in_meta_valid and in_meta_data.pkt_queue_id matches a valid entry, emit the packet with needs_dsc=1, consume the packet, remove that entry, increment merge_cnt and clear burst_cnt.
REQ-015 SHALL otherwise apply priority rule 2: if the table is non-empty and (burst_cnt >= MAX_PKT_BURST or !in_meta_valid), emit the oldest entry as descriptor-only, remove it and clear burst_cnt.
REQ-016 SHALL otherwise apply priority rule 3: if in_meta_valid, emit the packet unchanged with needs_dsc=0, and increment burst_cnt (saturating) when the table is non-empty, else clear it.
REQ-017 SHALL build descriptor-only output as all fields zero except pkt_queue_id = entry id and descriptor_only=1.
REQ-018 SHALL assert in_meta_ready combinationally only on a selection cycle where rule 1 or rule 3 fires.
REQ-019 SHALL NOT let a head update accepted in cycle N be merged or emitted before cycle N+1.
REQ-020 SHALL insert, not coalesce, a head update that matches an entry removed in the same cycle.
REQ-021 SHALL, when removal and insertion coincide with a full table, still deassert head_upd_ready (conservative rule).
REQ-022 SHALL compact the table on removal so that age order is preserved.
REQ-023 SHALL let counters wrap modulo 2^32.

Reset
REQ-024 SHALL, while rst is high, clear the table valid bits, burst_cnt, out_meta_valid, out_meta_data, merge_cnt and coalesce_cnt, and drive in_meta_ready=0 and head_upd_ready=0.
REQ-025 SHALL discard pending updates and any unaccepted output when reset asserts mid-operation; the first output after reset SHALL come from post-reset inputs only.

Verification
REQ-026 SHALL cover merge: head update q=5, then packet q=5 size=64 -> one output with needs_dsc=1, size=64, and merge_cnt=1.
REQ-027 SHALL cover idle update: head update q=3 with no packets -> output two cycles later with descriptor_only=1, queue 3, size=0.
REQ-028 SHALL cover starvation guard: pending q=7 plus continuous packets to q=1 -> exactly 8 packets, then descriptor-only q=7.
REQ-029 SHALL cover coalescing: three updates to q=9 back-to-back -> one pending entry, coalesce_cnt=2, and a single descriptor-only output.
REQ-030 SHALL cover full/backpressure: 4 distinct updates with out_meta_ready=0 -> head_upd_ready=0 for a 5th distinct id but 1 for a duplicate; on release, outputs come oldest first.
REQ-031 SHALL cover reset: rst pulsed with 2 pending entries and out_meta_valid=1 -> all outputs zero and no stale descriptor emitted afterwards.
